// File: rtl/table_dump_scan_if.sv
// rtl/table_dump_scan_if.sv - ASCII byte stream between the dump sequencer and UART TX
interface table_dump_scan_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/table_dump_scan.sv
// rtl/table_dump_scan.sv - walks the table selector row-major and streams each word as ASCII hex
module table_dump_scan #(
  parameter int         NUM_ROWS = 5,
  parameter int         NUM_COLS = 4,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [1:0]   col_sel,
  output logic [4:0]   row_sel,
  input  logic [31:0]  selected,
  table_dump_scan_if.master tx
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] HEX  = 3'd2;
  localparam logic [2:0] SEP  = 3'd3;
  localparam logic [2:0] CR   = 3'd4;
  localparam logic [2:0] LF   = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

  logic [2:0]  state;
  logic [2:0]  row_idx;
  logic [1:0]  col_idx;
  logic [2:0]  nib_idx;
  logic [31:0] word_q;
  logic [3:0]  nibble;
  logic        accept;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction

  assign nibble = word_q[{nib_idx, 2'b00} +: 4];
  assign accept = tx.out_valid && tx.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_idx <= '0;
      col_idx <= '0;
      nib_idx <= '0;
      word_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row_idx <= '0;
          col_idx <= '0;
          state   <= LOAD;
        end
        // The word is frozen here; later selector changes never reach the output.
        LOAD: begin
          word_q  <= selected;
          nib_idx <= 3'd7;
          state   <= HEX;
        end
        HEX: if (accept) begin
          if (nib_idx != 3'd0) nib_idx <= nib_idx - 3'd1;
          else state <= (col_idx < LAST_COL) ? SEP : CR;
        end
        SEP: if (accept) begin
          col_idx <= col_idx + 2'd1;
          state   <= LOAD;
        end
        CR: if (accept) state <= LF;
        LF: if (accept) begin
          col_idx <= '0;
          if (row_idx < LAST_ROW) begin
            row_idx <= row_idx + 3'd1;
            state   <= LOAD;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    col_sel      = col_idx;
    row_sel      = (state == LOAD) ? (5'(1) << row_idx) : 5'd0;
    tx.out_valid = 1'b0;
    tx.out_data  = 8'h00;
    case (state)
      HEX: begin tx.out_valid = 1'b1; tx.out_data = hex_char(nibble); end
      SEP: begin tx.out_valid = 1'b1; tx.out_data = SEP_CHAR;         end
      CR:  begin tx.out_valid = 1'b1; tx.out_data = 8'h0D;            end
      LF:  begin tx.out_valid = 1'b1; tx.out_data = 8'h0A;            end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_table_dump_scan.sv
// tb/tb_table_dump_scan.sv - scoreboard bench for the table dump sequencer
module tb_table_dump_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  col_sel;
  logic [4:0]  row_sel;
  logic [31:0] selected;

  table_dump_scan_if tx ();

  table_dump_scan dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .col_sel(col_sel), .row_sel(row_sel), .selected(selected), .tx(tx)
  );

  always #5 clk = ~clk;

  logic [31:0] tbl [5][4];
  bit          zero_sel;

  // Table selector model: one-hot row, column index.
  always_comb begin
    selected = 32'h0;
    if (!zero_sel)
      for (int r = 0; r < 5; r++)
        if (row_sel[r]) selected = tbl[r][col_sel];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q [$];
  logic [6:0] load_log [$];
  int         nbytes, ndone, last_acc_cyc;
  logic [7:0] last_byte, hold_data;
  bit         hold_pend, busy_chk_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hold_pend) begin
      chk("hold_valid", 32'(tx.out_valid), 32'd1);
      chk("hold_data", 32'(tx.out_data), 32'(hold_data));
      hold_pend = 1'b0;
    end
    if (busy_chk_pend) begin
      chk("busy_after_done", 32'(busy), 32'd0);
      busy_chk_pend = 1'b0;
    end
    if (!rst && row_sel != 5'd0) load_log.push_back({row_sel, col_sel});
    if (!rst && tx.out_valid && tx.out_ready) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 32'd1);
      else chk($sformatf("byte%0d", nbytes), 32'(tx.out_data), 32'(exp_q.pop_front()));
      nbytes++;
      last_acc_cyc = cyc;
      last_byte    = tx.out_data;
    end
    if (!rst && tx.out_valid && !tx.out_ready) begin
      hold_pend = 1'b1;
      hold_data = tx.out_data;
    end
    if (done) begin
      ndone++;
      chk("done_after_lf", 32'(cyc - last_acc_cyc), 32'd1);
      chk("done_last_byte", 32'(last_byte), 32'h0A);
      chk("done_busy", 32'(busy), 32'd1);
      busy_chk_pend = 1'b1;
    end
  end

  task automatic push_dump();
    string hx = "0123456789ABCDEF";
    logic [31:0] w;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        w = tbl[r][c];
        for (int n = 7; n >= 0; n--) exp_q.push_back(hx[w[4*n +: 4]]);
        if (c < 3) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic reset_counts();
    nbytes = 0;
    ndone  = 0;
    exp_q.delete();
    load_log.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit rnd);
    int i = 0;
    while (ndone == 0 && i < budget) begin
      @(posedge clk); #1;
      if (rnd) tx.out_ready = ($urandom % 2) == 1;
      i++;
    end
    tx.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_single_done"}, 32'(ndone), 32'd1);
    chk({tag, "_bytes"}, 32'(nbytes), 32'd185);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int i;
    rst = 1'b1; start = 1'b0; tx.out_ready = 1'b1; zero_sel = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        tbl[r][c] = {4'(r), 4'(c), 24'h00ABCD};
    reset_counts();
    hold_pend = 1'b0; busy_chk_pend = 1'b0; last_acc_cyc = 0; last_byte = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_col_sel", 32'(col_sel), 32'd0);
    chk("rst_row_sel", 32'(row_sel), 32'd0);
    chk("rst_out_data", 32'(tx.out_data), 32'd0);
    chk("rst_out_valid", 32'(tx.out_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Full dump at full rate, with start latency and LOAD sequence.
    reset_counts();
    push_dump();
    pulse_start();
    @(negedge clk);
    chk("lat_row_sel", 32'(row_sel), 32'h01);
    chk("lat_col_sel", 32'(col_sel), 32'd0);
    chk("lat_load_valid", 32'(tx.out_valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_first_valid", 32'(tx.out_valid), 32'd1);
    chk("lat_first_data", 32'(tx.out_data), 32'h30);
    wait_done("full", 1000, 1'b0);
    chk("load_count", 32'(load_log.size()), 32'd20);
    for (int k = 0; k < 20 && k < load_log.size(); k++)
      chk($sformatf("load%0d", k), 32'(load_log[k]), 32'({5'(1) << (k / 4), 2'(k % 4)}));

    // Random backpressure.
    reset_counts();
    push_dump();
    pulse_start();
    wait_done("bp", 4000, 1'b1);

    // Second start mid-dump is ignored.
    reset_counts();
    push_dump();
    pulse_start();
    repeat (60) @(posedge clk);
    pulse_start();
    wait_done("restart", 1000, 1'b0);

    // Reset during the third row's HEX output.
    reset_counts();
    push_dump();
    pulse_start();
    i = 0;
    while (i < 500 && row_sel != 5'b00100) begin
      @(negedge clk);
      i++;
    end
    chk("row2_load_seen", 32'(row_sel), 32'h04);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1; tx.out_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0; tx.out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(tx.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_row_sel", 32'(row_sel), 32'd0);
    reset_counts();
    push_dump();
    pulse_start();
    wait_done("after_rst", 1000, 1'b0);
    chk("after_rst_first_load", 32'(load_log.size() > 0 ? load_log[0] : 7'h7F), 32'h04);

    // Snapshot: selector drops to zero right after the first LOAD.
    tbl[0][0] = 32'hFEDC3210;
    reset_counts();
    push_dump();
    pulse_start();
    @(posedge clk); #1 zero_sel = 1'b1;
    repeat (3) @(posedge clk);
    #1 zero_sel = 1'b0;
    wait_done("snapshot", 1000, 1'b0);
    tbl[0][0] = 32'h0000ABCD;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
